// File: rtl/mips_pkg.sv
// Shared write-back definitions: register-file widths, the queued entry
// layout and the hard-wired zero register.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbuf_fwd_match.sv
// Youngest-match search over the live window [head, head+count) of the
// write buffer; one instance per register-file read port.
module wbuf_fwd_match #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic [ADDR_W-1:0] q_addr [DEPTH],
  input  logic [DATA_W-1:0] q_data [DEPTH],
  input  logic [PW-1:0]     head,
  input  logic [CW-1:0]     count,
  input  logic [ADDR_W-1:0] raddr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);
  import mips_pkg::*;

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (raddr != ADDR_W'(REG_ZERO)) && (q_addr[idx] == raddr)) begin
        hit  = 1'b1;
        data = q_data[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_buffer.sv
// In-order write queue in front of the register file's single write port,
// merging ALU and mult/div results and forwarding uncommitted values.
module regfile_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] write,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] read1,
  input  logic [ADDR_W-1:0] read2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);
  import mips_pkg::*;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     free;
  logic              alu_enq;
  logic              md_enq;
  logic              deq;
  logic [CW-1:0]     enq_cnt;
  logic [PW-1:0]     md_slot;

  // Space is judged on the registered count only; the ALU owns the last slot.
  assign free      = CW'(DEPTH) - count;
  assign alu_ready = (free >= CW'(1));
  assign md_ready  = (free >= CW'(2)) || ((free == CW'(1)) && !alu_valid);

  // Writes to $0 complete the handshake but never occupy a slot.
  assign alu_enq = alu_valid && alu_ready && (alu_addr != ADDR_W'(REG_ZERO));
  assign md_enq  = md_valid  && md_ready  && (md_addr  != ADDR_W'(REG_ZERO));
  assign deq     = (count != '0);
  assign enq_cnt = CW'(alu_enq) + CW'(md_enq);
  assign md_slot = tail + PW'(alu_enq);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq);
      tail  <= tail + PW'(enq_cnt);
      count <= count + enq_cnt - CW'(deq);
    end
  end

  always_ff @(posedge CLK) begin
    if (alu_enq) begin
      q_addr[tail] <= alu_addr;
      q_data[tail] <= alu_data;
    end
    if (md_enq) begin
      q_addr[md_slot] <= md_addr;
      q_data[md_slot] <= md_data;
    end
  end

  // Head entry drives the write port directly; it commits on the next edge.
  assign RegWrite  = deq;
  assign write     = deq ? q_addr[head] : '0;
  assign writeData = deq ? q_data[head] : '0;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  wbuf_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
    .q_addr (q_addr),
    .q_data (q_data),
    .head   (head),
    .count  (count),
    .raddr  (read1),
    .hit    (fwd1_hit),
    .data   (fwd1_data)
  );

  wbuf_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
    .q_addr (q_addr),
    .q_data (q_data),
    .head   (head),
    .count  (count),
    .raddr  (read2),
    .hit    (fwd2_hit),
    .data   (fwd2_data)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      assert (count <= CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Randomised scoreboard bench for regfile_write_buffer with a queue-based
// reference model and an independent commit monitor.
module tb_regfile_write_buffer;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        reset;
  logic        alu_valid, md_valid;
  logic [4:0]  alu_addr, md_addr;
  logic [31:0] alu_data, md_data;
  logic        alu_ready, md_ready;
  logic        RegWrite;
  logic [4:0]  write;
  logic [31:0] writeData;
  logic [4:0]  read1, read2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic [2:0]  count;
  logic        full, empty;

  regfile_write_buffer #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .md_valid  (md_valid),
    .md_addr   (md_addr),
    .md_data   (md_data),
    .md_ready  (md_ready),
    .RegWrite  (RegWrite),
    .write     (write),
    .writeData (writeData),
    .read1     (read1),
    .read2     (read2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  wb_entry_t mq[$];     // model of what is pending in the buffer
  wb_entry_t exp_q[$];  // commits the monitor should observe, in order
  int n_cmp  = 0;
  int n_fail = 0;
  logic m_ar, m_mr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fwd_model(input logic [4:0] r, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (r != 5'd0)
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].addr == r) begin
          hit = 1'b1;
          d   = mq[i].data;
        end
  endtask

  task automatic check_now();
    int n, fr;
    logic h1, h2;
    logic [31:0] d1, d2;
    n  = mq.size();
    fr = DEPTH - n;
    m_ar = (fr >= 1);
    m_mr = (fr >= 2) || (fr == 1 && !alu_valid);
    chk("alu_ready", alu_ready, m_ar);
    chk("md_ready", md_ready, m_mr);
    chk("count", count, n);
    chk("full", full, n == DEPTH);
    chk("empty", empty, n == 0);
    chk("RegWrite", RegWrite, n > 0);
    chk("write", write, (n > 0) ? mq[0].addr : 5'd0);
    chk("writeData", writeData, (n > 0) ? mq[0].data : 32'd0);
    fwd_model(read1, h1, d1);
    fwd_model(read2, h2, d2);
    chk("fwd1_hit", fwd1_hit, h1);
    chk("fwd1_data", fwd1_data, d1);
    chk("fwd2_hit", fwd2_hit, h2);
    chk("fwd2_data", fwd2_data, d2);
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge CLK);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    md_valid  = mv; md_addr  = ma; md_data  = md;
    read1 = r1; read2 = r2;
    #1;
    check_now();
  endtask

  task automatic advance();
    wb_entry_t e;
    @(posedge CLK);
    if (mq.size() > 0) void'(mq.pop_front());
    if (alu_valid && m_ar && alu_addr != 5'd0) begin
      e.addr = alu_addr; e.data = alu_data;
      mq.push_back(e); exp_q.push_back(e);
    end
    if (md_valid && m_mr && md_addr != 5'd0) begin
      e.addr = md_addr; e.data = md_data;
      mq.push_back(e); exp_q.push_back(e);
    end
  endtask

  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic [4:0] r1, input logic [4:0] r2);
    drive(av, aa, ad, mv, ma, md, r1, r2);
    advance();
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  // Monitor: every cycle that presents RegWrite is one commit at the next edge.
  initial begin
    wb_entry_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (reset && RegWrite) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL commit_unexpected: got write=%0d data=%0h expected no write", write, writeData);
        end else begin
          e = exp_q.pop_front();
          chk("commit_addr", write, e.addr);
          chk("commit_data", writeData, e.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    md_valid = 0; md_addr = 0; md_data = 0;
    read1 = 5'd2; read2 = 5'd3;
    @(posedge CLK);
    #1;
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_write", write, 0);
    chk("rst_writeData", writeData, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_fwd1_hit", fwd1_hit, 0);
    chk("rst_fwd2_data", fwd2_data, 0);
    @(posedge CLK);
    #2 reset = 1'b1;

    // Single ALU write
    step(1, 5'd2, 32'h2, 0, 0, 0, 5'd2, 0);
    drive(0, 0, 0, 0, 0, 0, 5'd2, 0);
    chk("single_write_addr", write, 5'd2);
    advance();
    idle(5'd2, 0);

    // Both sources in one cycle: ALU older
    step(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 5'd3, 5'd4);
    drive(0, 0, 0, 0, 0, 0, 5'd3, 5'd4);
    chk("dual_count", count, 3'd2);
    advance();
    idle(5'd3, 5'd4);
    idle(5'd3, 5'd4);

    // Fill until only the last slot is free
    step(1, 5'd6, 32'h66, 1, 5'd7, 32'h77, 5'd6, 5'd7);
    step(1, 5'd8, 32'h88, 1, 5'd9, 32'h99, 5'd8, 5'd9);
    drive(1, 5'd10, 32'haa, 1, 5'd11, 32'hbb, 5'd10, 5'd11);
    chk("last_slot_alu_ready", alu_ready, 1);
    chk("last_slot_md_ready", md_ready, 0);
    advance();
    repeat (4) idle(5'd9, 5'd10);

    // Same-address duplicates: younger wins forwarding
    step(1, 5'd5, 32'h10, 1, 5'd5, 32'h20, 5'd5, 0);
    drive(0, 0, 0, 0, 0, 0, 5'd5, 0);
    chk("dup_fwd1_data", fwd1_data, 32'h20);
    chk("dup_fwd2_hit", fwd2_hit, 0);
    advance();
    idle(5'd5, 0);
    idle(5'd5, 0);

    // Register zero is consumed, not queued
    drive(1, 5'd0, 32'hffff, 0, 0, 0, 0, 0);
    chk("zero_alu_ready", alu_ready, 1);
    advance();
    idle(0, 0);

    // Async reset between edges with entries pending
    step(1, 5'd12, 32'hc1, 1, 5'd13, 32'hd1, 5'd12, 5'd13);
    step(1, 5'd14, 32'he1, 0, 0, 0, 5'd12, 5'd14);
    alu_valid = 0; md_valid = 0;
    @(negedge CLK);
    #3 reset = 1'b0;
    #1;
    chk("midrst_RegWrite", RegWrite, 0);
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_fwd1_hit", fwd1_hit, 0);
    mq.delete();
    exp_q.delete();
    @(posedge CLK);
    #2 reset = 1'b1;
    repeat (3) idle(5'd12, 5'd14);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
           ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom(),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    for (int k = 0; k < 4 * DEPTH && mq.size() > 0; k++) idle(0, 0);
    @(negedge CLK);
    #3;
    chk("drained_model", mq.size(), 0);
    chk("drained_scoreboard", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
